ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//  Implements inhibit, request-to-send, 11-bit device-clocked frame and ACK check.
//  Sits beside the keyboard receive path; the top level maps *_oe onto the open-drain PS2_CLK/PS2_DATA pads.
//  The receiver must ignore the bus while tx_busy=1.
// PARAMETERS
//  CLK_HZ            100_000_000  system clock frequency
//  INHIBIT_US        100          clock-inhibit time before RTS
//  START_TIMEOUT_US  15000        max wait from clock release to first device falling edge
//  XFER_TIMEOUT_US   2000         max time from first falling edge to ACK sample
//  FILTER_LEN        8            consecutive equal samples needed to accept a new PS/2 clock level
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-high reset
//  tx_data     in   8  byte to send; latched when tx_start is accepted
//  tx_start    in   1  request; accepted only when tx_ready=1, otherwise ignored
//  tx_ready    out  1  1 in IDLE
//  tx_busy     out  1  ~tx_ready
//  tx_done     out  1  1-cycle pulse: frame sent and ACKed
//  tx_err      out  1  1-cycle pulse: frame failed
//  err_code    out  2  valid with tx_err and held until the next accept: 1 start timeout, 2 xfer timeout, 3 NACK
//  ps2_clk_i   in   1  PS/2 clock pad level (async)
//  ps2_data_i  in   1  PS/2 data pad level (async)
//  ps2_clk_oe  out  1  1 = drive PS/2 clock low
//  ps2_data_oe out  1  1 = drive PS/2 data low
// BEHAVIOUR
//  Reset values: tx_ready=1, tx_busy=0, tx_done=0, tx_err=0, err_code=0, ps2_clk_oe=0, ps2_data_oe=0; state=IDLE.
//  Input conditioning:
//   - ps2_clk_i and ps2_data_i pass through 2-FF synchronisers.
//   - The clock then goes through a FILTER_LEN glitch filter.
//   - A falling edge (fe) is a 1-cycle strobe on the filtered-clock 1->0 transition.
//  Cycle-count constants: N = CLK_HZ/1_000_000 * US. Counters are sized with $clog2.
//  FSM:
//   IDLE: both oe=0.
//     - tx_start && tx_ready: latch the byte, compute odd parity P = ~^tx_data, clear err_code, go INHIBIT.
//   INHIBIT: clk_oe=1, data_oe=0 for exactly N(INHIBIT_US) cycles, then RTS.
//   RTS: clk_oe=1, data_oe=1 for 1 cycle (start bit), then REQ.
//   REQ: clk_oe=0, data_oe=1; the start-timeout counter runs.
//     - fe: bit_idx=0, load data_oe=~byte[0], go SEND.
//     - N(START_TIMEOUT_US) cycles with no fe: err_code=1.
//   SEND: on each fe, bit_idx++ and data_oe is updated.
//     - Data bits are sent LSB first.
//     - After byte[7]: data_oe=~P.
//     - Next fe: data_oe=0 (stop bit), go ACK.
//     - data_oe changes only on the cycle after fe.
//   ACK: data_oe=0.
//     - Next fe: sample synchronised data.
//     - Sample 0: go WAIT_IDLE.
//     - Sample 1: err_code=3.
//   WAIT_IDLE: wait until filtered clk=1 and synced data=1 for the same cycle, then tx_done pulse and IDLE.
//  Timing relative to the first fe:
//   - fe#2..#8 shift data bits 1..7.
//   - fe#9 outputs P.
//   - fe#10 releases data (stop bit).
//   - fe#11 samples ACK.
//  Xfer timeout: a counter starts at the first fe and runs through SEND/ACK/WAIT_IDLE. Reaching N(XFER_TIMEOUT_US) sets err_code=2.
//  Any error:
//   - In the same cycle: tx_err=1, both oe=0, state goes to IDLE.
//   - tx_ready=1 on the next cycle.
//  The new tx_start is sampled only in IDLE, so a start pulse in the same cycle as tx_done/tx_err is ignored.
//  tx_data changes after acceptance have no effect.
//  rst mid-operation: both oe drop to 0 immediately (async); counters and bit_idx clear.
// TESTING
//  1. Device model clocks at 12.5 kHz and ACKs; send 0xED.
//     -> data seen at device rising edges: 0,1,0,1,1,0,1,1,1,1,1 (start, LSB-first data, parity 1, stop 1).
//     -> tx_done pulse once, err_code=0.
//  2. CLK_HZ=100e6, send 0xFF (parity 1).
//     -> clk_oe=1/data_oe=0 for exactly 10000 cycles, then 1 cycle with both oe=1, then clk_oe=0 with data_oe=1.
//  3. Send 0x00 (parity 1); device returns data=1 at fe#11.
//     -> tx_err, err_code=3, both oe=0.
//  4. No device clock after RTS.
//     -> tx_err with err_code=1 exactly 1_500_000 cycles after entering REQ; tx_ready=1 the next cycle.
//  5. Device stops after 5 falling edges.
//     -> err_code=2 200_000 cycles after the first fe.
//     -> A 3-cycle low glitch on ps2_clk_i during SEND produces no bit advance.
//  6. Assert rst during SEND bit 4.
//     -> oe=0 immediately, tx_ready=1 after release.
//     -> tx_start pulses while tx_busy=1 are ignored (byte unchanged).

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked
// 11-bit frame (start, 8 data LSB first, odd parity, stop) and ACK check.
module ps2_host_tx #(
  parameter int unsigned CLK_HZ           = 100_000_000,
  parameter int unsigned INHIBIT_US       = 100,
  parameter int unsigned START_TIMEOUT_US = 15000,
  parameter int unsigned XFER_TIMEOUT_US  = 2000,
  parameter int unsigned FILTER_LEN       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned CYC_PER_US = CLK_HZ / 1_000_000;
  localparam int unsigned N_INHIBIT  = CYC_PER_US * INHIBIT_US;
  localparam int unsigned N_START    = CYC_PER_US * START_TIMEOUT_US;
  localparam int unsigned N_XFER     = CYC_PER_US * XFER_TIMEOUT_US;
  localparam int unsigned N_STEP_MAX = (N_INHIBIT > N_START) ? N_INHIBIT : N_START;
  localparam int unsigned STEP_W     = $clog2(N_STEP_MAX + 1);
  localparam int unsigned XFER_W     = $clog2(N_XFER + 1);
  localparam int unsigned FILT_W     = $clog2(FILTER_LEN + 1);

  localparam logic [1:0] ERR_START = 2'd1;
  localparam logic [1:0] ERR_XFER  = 2'd2;
  localparam logic [1:0] ERR_NACK  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t              state;
  logic [1:0]          clk_sync;
  logic [1:0]          data_sync;
  logic                clk_filt;
  logic [FILT_W-1:0]   filt_cnt;
  logic                fe;
  logic [7:0]          tx_byte;
  logic                parity;
  logic [3:0]          bit_idx;
  logic [STEP_W-1:0]   step_cnt;
  logic [XFER_W-1:0]   xfer_cnt;

  logic clk_s;
  logic data_s;
  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // Pad synchronisers; the idle bus level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
    end
  end

  // Clock glitch filter; fe is high in the first cycle the filtered clock reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fe       <= 1'b0;
    end else begin
      fe <= 1'b0;
      if (clk_s == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s;
        filt_cnt <= '0;
        fe       <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + FILT_W'(1);
      end
    end
  end

  // Transmit sequencer. After done/error the state is IDLE with tx_ready still
  // low for one cycle, so a start coinciding with tx_done/tx_err is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      tx_ready    <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      err_code    <= 2'd0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_byte     <= 8'd0;
      parity      <= 1'b0;
      bit_idx     <= 4'd0;
      step_cnt    <= '0;
      xfer_cnt    <= '0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (!tx_ready) begin
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
          end else if (tx_start) begin
            tx_byte    <= tx_data;
            parity     <= ~^tx_data;
            err_code   <= 2'd0;
            step_cnt   <= '0;
            tx_ready   <= 1'b0;
            tx_busy    <= 1'b1;
            ps2_clk_oe <= 1'b1;
            state      <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (step_cnt == STEP_W'(N_INHIBIT - 1)) begin
            step_cnt    <= '0;
            ps2_data_oe <= 1'b1;
            state       <= S_RTS;
          end else begin
            step_cnt <= step_cnt + STEP_W'(1);
          end
        end

        S_RTS: begin
          ps2_clk_oe <= 1'b0;
          state      <= S_REQ;
        end

        S_REQ: begin
          if (fe) begin
            bit_idx     <= 4'd0;
            ps2_data_oe <= ~tx_byte[0];
            tx_byte     <= {1'b0, tx_byte[7:1]};
            xfer_cnt    <= XFER_W'(1);
            state       <= S_SEND;
          end else if (step_cnt == STEP_W'(N_START - 1)) begin
            tx_err      <= 1'b1;
            err_code    <= ERR_START;
            ps2_data_oe <= 1'b0;
            state       <= S_IDLE;
          end else begin
            step_cnt <= step_cnt + STEP_W'(1);
          end
        end

        S_SEND, S_ACK, S_WAIT_IDLE: begin
          if (xfer_cnt == XFER_W'(N_XFER - 1)) begin
            tx_err      <= 1'b1;
            err_code    <= ERR_XFER;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            state       <= S_IDLE;
          end else begin
            xfer_cnt <= xfer_cnt + XFER_W'(1);
            if (state == S_SEND) begin
              if (fe) begin
                bit_idx <= bit_idx + 4'd1;
                if (bit_idx < 4'd7) begin
                  ps2_data_oe <= ~tx_byte[0];
                  tx_byte     <= {1'b0, tx_byte[7:1]};
                end else if (bit_idx == 4'd7) begin
                  ps2_data_oe <= ~parity;
                end else begin
                  ps2_data_oe <= 1'b0;
                  state       <= S_ACK;
                end
              end
            end else if (state == S_ACK) begin
              ps2_data_oe <= 1'b0;
              if (fe) begin
                if (!data_s) begin
                  state <= S_WAIT_IDLE;
                end else begin
                  tx_err   <= 1'b1;
                  err_code <= ERR_NACK;
                  state    <= S_IDLE;
                end
              end
            end else if (clk_filt && data_s) begin
              tx_done <= 1'b1;
              state   <= S_IDLE;
            end
          end
        end

        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural keyboard model,
// frames checked against bit sequences derived from the byte, plus timeouts.
module tb_ps2_host_tx;

  localparam int unsigned CLK_HZ   = 1_000_000;
  localparam int unsigned INH_US   = 100;
  localparam int unsigned START_US = 600;
  localparam int unsigned XFER_US  = 700;
  localparam int N_INH   = 100;
  localparam int N_START = 600;
  localparam int N_XFER  = 700;
  localparam int HALF    = 25;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready, tx_busy, tx_done, tx_err;
  logic [1:0] err_code;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk, dev_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  logic [1:0] err_code_seen = 2'd0;
  logic [1:0] err_oe_seen = 2'd0;
  logic ready_after_err = 1'b0;
  logic err_prev = 1'b0;

  ps2_host_tx #(
    .CLK_HZ(CLK_HZ), .INHIBIT_US(INH_US), .START_TIMEOUT_US(START_US),
    .XFER_TIMEOUT_US(XFER_US), .FILTER_LEN(8)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
    .err_code(err_code), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  // Wired-AND open-drain bus
  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder
  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (err_prev) ready_after_err = tx_ready;
    if (tx_err) begin
      err_cnt++;
      err_cyc = cyc;
      err_code_seen = err_code;
      err_oe_seen = {ps2_clk_oe, ps2_data_oe};
    end
    err_prev = tx_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic frame(input logic [7:0] b, input int n_fe, input bit nack,
                       input bit glitch, input int rst_at);
    logic [10:0] exp_bits;
    logic [10:0] got_bits;
    int n, base_done, base_err, t_req, t_chg;
    bit seen;
    exp_bits  = {1'b1, ~^b, b, 1'b0};
    got_bits  = '0;
    base_done = done_cnt;
    base_err  = err_cnt;
    @(negedge clk); tx_data = b; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0; tx_data = ~b;
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 4 * N_INH) begin
      @(negedge clk); n++;
    end
    check("inhibit_cycles", n, N_INH);
    check("rts_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 3);
    @(negedge clk);
    check("req_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 1);
    t_req = cyc;
    if (n_fe == 0) begin
      n = 0;
      while (err_cnt == base_err && n < 2 * N_START) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      check("start_timeout_cycles", err_cyc - t_req, N_START);
      check("start_timeout_code", err_code_seen, 1);
      check("start_timeout_oe", err_oe_seen, 0);
      check("ready_after_err", ready_after_err, 1);
      check("err_code_held", err_code, 1);
      return;
    end
    repeat (HALF) @(negedge clk);
    got_bits[0] = ps2_data_i;
    seen = 1'b0;
    t_chg = 0;
    for (int i = 1; i <= n_fe; i++) begin
      if (i == 11) dev_data = nack;
      dev_clk = 1'b0;
      for (int k = 0; k < HALF; k++) begin
        @(negedge clk);
        if (i == 1 && !seen && !ps2_data_oe) begin seen = 1'b1; t_chg = cyc; end
        if (i == rst_at && k == HALF / 2) begin
          #2 rst = 1'b1;
          #1;
          check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
          check("rst_ready", tx_ready, 1);
          @(negedge clk); rst = 1'b0; dev_clk = 1'b1; dev_data = 1'b1;
          @(negedge clk);
          check("ready_after_rst", tx_ready, 1);
          check("busy_after_rst", tx_busy, 0);
          return;
        end
      end
      dev_clk = 1'b1;
      for (int k = 0; k < HALF; k++) begin
        @(negedge clk);
        if (k == 2 && i <= 10) got_bits[i] = ps2_data_i;
        if (glitch && i == 4) dev_clk = !(k >= 12 && k < 15);
        if (i == 5 && k == 3) begin tx_start = 1'b1; tx_data = ~b; end
        if (i == 5 && k == 4) tx_start = 1'b0;
      end
    end
    dev_data = 1'b1;
    if (n_fe < 11) begin
      n = 0;
      while (err_cnt == base_err && n < 2 * N_XFER) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      check("xfer_first_bit_seen", seen, 1);
      check("xfer_timeout_cycles", err_cyc - t_chg, N_XFER - 1);
      check("xfer_timeout_code", err_code_seen, 2);
      check("xfer_timeout_oe", err_oe_seen, 0);
      check("ready_after_err", ready_after_err, 1);
      return;
    end
    check("frame_bits", got_bits, exp_bits);
    n = 0;
    while (done_cnt == base_done && err_cnt == base_err && n < 8 * HALF) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    if (nack) begin
      check("nack_err_pulses", err_cnt - base_err, 1);
      check("nack_code", err_code_seen, 3);
      check("nack_oe", err_oe_seen, 0);
      check("nack_done_pulses", done_cnt - base_done, 0);
    end else begin
      check("done_pulses", done_cnt - base_done, 1);
      check("err_pulses", err_cnt - base_err, 0);
      check("done_code", err_code, 0);
    end
    check("idle_after", {29'd0, tx_ready, ps2_clk_oe, ps2_data_oe}, 4);
  endtask

  initial begin
    rst = 1'b1; tx_start = 1'b0; tx_data = 8'd0; dev_clk = 1'b1; dev_data = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ready", tx_ready, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_done", tx_done, 0);
    check("reset_err", tx_err, 0);
    check("reset_code", err_code, 0);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_data_oe", ps2_data_oe, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    frame(8'hED, 11, 1'b0, 1'b0, 0);
    frame(8'hFF, 11, 1'b0, 1'b1, 0);
    frame(8'h00, 11, 1'b1, 1'b0, 0);
    frame(8'($urandom), 0, 1'b0, 1'b0, 0);
    frame(8'($urandom) | 8'h01, 5, 1'b0, 1'b0, 0);
    frame(8'($urandom), 11, 1'b0, 1'b0, 5);
    for (int t = 0; t < 8; t++)
      frame(8'($urandom), 11, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
